conv_window_gen: RTL
====================

# conv_window_gen

Upstream feeder for the 3x3 convolution stage. It scans the 25x32 image ROM in row-major order, one pixel address at a time. It keeps the two previous image rows in line buffers and emits every complete 3x3 window (23x30 = 690 windows) over a valid/ready handshake, so the convolution array no longer needs a full-frame register copy of the image.

## Interface
- IMG_ROWS, 25, image rows read from ROM
- IMG_COLS, 32, image columns read from ROM
- PIX_W, 4, window pixel width
- ROM_W, 12, ROM data width
- SRC_MSB, 11, MSB of the 3-bit pixel field in ROM data; field is rom_data[SRC_MSB -: 3], zero-extended to PIX_W
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame scan; sampled in IDLE only
- rom_row  out  6  ROM row address
- rom_col  out  9  ROM column address
- rom_data  in  ROM_W  ROM read data, valid one cycle after address (synchronous ROM)
- win_valid  out  1  window available
- win_ready  in  1  consumer accepts window
- win_pix  out  9*PIX_W  lane k = pixel (win_row + k/3, win_col + k%3), lane 0 at LSBs
- win_row  out  5  window top-left row, 0..22
- win_col  out  5  window top-left column, 0..29
- busy  out  1  high in ADDR, DATA, EMIT
- done  out  1  one-cycle pulse after last window accepted

## Operation
- States: IDLE, ADDR, DATA, EMIT, DONE.
- IDLE: start=1 -> clear pixel counters (r,c)=(0,0) -> ADDR.
- ADDR: drive rom_row=r, rom_col=c -> DATA.
- DATA: capture p = zero-extended field of rom_data.
  - Shift the window left; the new right column is {lb0[c], lb1[c], p} (top to bottom).
  - Write back lb0[c] <= lb1[c] and lb1[c] <= p. Line buffers are read-before-write.
  - If r>=2 and c>=2: load win_row=r-2, win_col=c-2 and go to EMIT.
  - Otherwise advance (r,c) and go to ADDR.
- EMIT: win_valid=1. On win_ready=1, advance (r,c); go to DONE if (r,c) was (24,31), else ADDR. On win_ready=0, stay.
- Advance rule: c wraps at IMG_COLS-1 to 0 with r+1.
- DONE: done=1 for one cycle -> IDLE.
- start is ignored outside IDLE, including in DONE.
- Line buffers are not cleared by reset; rows 0 and 1 always overwrite them before any window uses them.
- The window shift register is reloaded column by column. Stale columns from the previous row are flushed by pixels (r,0),(r,1) before the window at column 0 is emitted.

## Timing
- Reset values: rom_row=0, rom_col=0, win_valid=0, win_pix=0, win_row=0, win_col=0, busy=0, done=0; state IDLE.
- rst during any state aborts the frame; IDLE is reached on the next cycle.
- All outputs are registered.
- While win_valid=1 and win_ready=0: win_pix, win_row, win_col and rom address are held stable. No ROM advance occurs.
- Cost per pixel: 2 cycles without a window; 3 cycles with a window when win_ready=1.
- With win_ready tied high:
  - Cycle 1 is the first cycle after the start edge.
  - First win_valid is in cycle 135.
  - Last window is in cycle 2290; done is in cycle 2291.
  - Total = 110·2 + 690·3.
- Each cycle of backpressure delays all later events by exactly one cycle.
- Row wrap: after window (i,29), the next window is (i+1,0), at least 4 cycles later (pixels (r,0),(r,1) produce no window).

## Structure
- Package conv_pkg holds:
  - IMG_ROWS, IMG_COLS, PIX_W, KERNEL=3
  - OUT_ROWS=23, OUT_COLS=30
  - the state enum {IDLE, ADDR, DATA, EMIT, DONE}
  - a lane index helper constant table
- Sub-module conv_line_buffer: IMG_COLS x PIX_W register array, one read and one write port, same address, read-before-write. Two instances (lb0, lb1).

## Test plan
- The bench ROM model is synchronous and returns field value (row+col)%8.
- Ready tied high, start pulse:
  - win_valid first rises in cycle 135 with (0,0) and lanes {0,1,2,1,2,3,2,3,4}.
  - Exactly 690 windows are emitted; done rises in cycle 2291.
- Row wrap: window (0,29) has lanes {5,6,7,6,7,0,7,0,1}. The next window is (1,0) with lanes {1,2,3,2,3,4,3,4,5}, and win_valid is low for at least 4 cycles between them.
- Backpressure: win_ready low for 5 cycles at window (0,0):
  - win_pix, win_row, win_col, rom_row and rom_col stay constant.
  - done shifts to cycle 2296.
  - Window contents are unchanged.
- Last window (22,29): lanes {3,4,5,4,5,6,5,6,7}; done pulses for exactly 1 cycle; busy falls on the same edge.
- Reset mid-frame: rst asserted while win_valid for window 100 is held.
  - Next cycle: all outputs are at reset values.
  - A new start reproduces the full sequence from (0,0) with identical lanes.
- start pulsed during EMIT and DONE: no effect. Window count stays 690 and no second frame begins until start is pulsed in IDLE.

Source files
------------

// File: rtl/conv_window_gen_pkg.sv
// conv_pkg: shared constants and types for the 3x3 window generator.
//   Image geometry, pixel/ROM widths, the control-state enum and the
//   lane -> (row, col) lookup tables used to pack the output window.
package conv_pkg;

    localparam int IMG_ROWS = 25;
    localparam int IMG_COLS = 32;
    localparam int PIX_W    = 4;
    localparam int ROM_W    = 12;
    localparam int SRC_MSB  = 11;
    localparam int KERNEL   = 3;

    localparam int OUT_ROWS = IMG_ROWS - KERNEL + 1;
    localparam int OUT_COLS = IMG_COLS - KERNEL + 1;
    localparam int LANES    = KERNEL * KERNEL;

    // Counter widths: 0..24 rows and 0..31 columns both fit in 5 bits.
    localparam int ROW_W = 5;
    localparam int COL_W = 5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    // Lane k of the packed window holds pixel (top + LANE_ROW[k], left + LANE_COL[k]).
    typedef int lane_tab_t [LANES];
    localparam lane_tab_t LANE_ROW = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    localparam lane_tab_t LANE_COL = '{0, 1, 2, 0, 1, 2, 0, 1, 2};

endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: valid/ready window channel towards the convolution array.
//   win_valid  window available          (master -> slave)
//   win_ready  consumer accepts window   (slave  -> master)
//   win_pix    9 lanes of PIX_W bits, lane 0 at LSBs
//   win_row    window top-left row    (0..22)
//   win_col    window top-left column (0..29)
interface conv_window_gen_if;
    import conv_pkg::*;

    logic                     win_valid;
    logic                     win_ready;
    logic [LANES*PIX_W-1:0]   win_pix;
    logic [4:0]               win_row;
    logic [4:0]               win_col;

    modport master (
        output win_valid,
        output win_pix,
        output win_row,
        output win_col,
        input  win_ready
    );

    modport slave (
        input  win_valid,
        input  win_pix,
        input  win_row,
        input  win_col,
        output win_ready
    );

endinterface

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: one image row of pixels held in registers.
//   clk      clock
//   i_addr   shared read/write column address
//   i_we     write enable
//   i_wdata  pixel written at i_addr
//   o_rdata  pixel stored at i_addr (combinational read, returns the old
//            value in the cycle of a write to the same address)
// Contents are deliberately not reset: every entry is rewritten by the
// first two image rows before any window reads it.
module conv_line_buffer #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic                     i_we,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: scans the 25x32 image ROM row-major and emits every
// complete 3x3 window over a valid/ready channel.
//   clk       clock, all logic on rising edge
//   rst       synchronous active-high reset, aborts any frame
//   start     begin one frame scan (only looked at in IDLE)
//   rom_row   ROM row address    (registered)
//   rom_col   ROM column address (registered)
//   rom_data  synchronous ROM data, valid the cycle after the address
//   win       window channel (master side)
//   busy      high while scanning (ADDR/DATA/EMIT)
//   done      one-cycle pulse after the last window is accepted
// Each pixel takes ADDR (address out) and DATA (capture). Pixels with
// r>=2 and c>=2 complete a window and add one EMIT cycle per offer.
module conv_window_gen
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [5:0]       rom_row,
    output logic [8:0]       rom_col,
    input  logic [ROM_W-1:0] rom_data,
    conv_window_gen_if.master win,
    output logic             busy,
    output logic             done
);

    state_t             r_state;
    state_t             w_next_state;

    logic [ROW_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;

    logic [PIX_W-1:0]   r_win [KERNEL][KERNEL];
    logic               r_win_valid;
    logic [4:0]         r_win_row;
    logic [4:0]         r_win_col;
    logic               r_busy;
    logic               r_done;

    logic [PIX_W-1:0]   w_pix;
    logic [PIX_W-1:0]   w_lb0_rd;
    logic [PIX_W-1:0]   w_lb1_rd;

    logic               w_capture;
    logic               w_has_win;
    logic               w_last_pix;
    logic               w_advance;
    logic               w_clear;

    logic               w_unused_rom;

    // The pixel lives in a 3-bit field of the ROM word; other bits are ignored.
    assign w_pix        = PIX_W'(rom_data[SRC_MSB -: 3]);
    assign w_unused_rom = ^rom_data[SRC_MSB-3:0];

    assign w_has_win  = (r_row >= 5'd2) && (r_col >= 5'd2);
    assign w_last_pix = (r_row == 5'(IMG_ROWS - 1)) && (r_col == 5'(IMG_COLS - 1));

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (start) w_next_state = ADDR;
            ADDR: w_next_state = DATA;
            DATA: w_next_state = w_has_win ? EMIT : ADDR;
            EMIT: begin
                if (win.win_ready) begin
                    w_next_state = w_last_pix ? DONE : ADDR;
                end
            end
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ---- control strobes ----
    always_comb begin
        w_clear   = 1'b0;
        w_capture = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            IDLE: w_clear = start;
            DATA: begin
                w_capture = 1'b1;
                w_advance = !w_has_win;
            end
            // The final pixel does not advance so the counters never leave the image.
            EMIT: w_advance = win.win_ready && !w_last_pix;
            default: ;
        endcase
    end

    // ---- pixel counters (double as the registered ROM address) ----
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_advance) begin
            if (r_col == 5'(IMG_COLS - 1)) begin
                r_col <= '0;
                r_row <= r_row + 5'd1;
            end else begin
                r_col <= r_col + 5'd1;
            end
        end
    end

    // ---- line buffers: lb0 holds row r-2, lb1 holds row r-1 ----
    conv_line_buffer #(
        .DEPTH (IMG_COLS),
        .WIDTH (PIX_W)
    ) u_lb0 (
        .clk     (clk),
        .i_addr  (r_col),
        .i_we    (w_capture),
        .i_wdata (w_lb1_rd),
        .o_rdata (w_lb0_rd)
    );

    conv_line_buffer #(
        .DEPTH (IMG_COLS),
        .WIDTH (PIX_W)
    ) u_lb1 (
        .clk     (clk),
        .i_addr  (r_col),
        .i_we    (w_capture),
        .i_wdata (w_pix),
        .o_rdata (w_lb1_rd)
    );

    // ---- window shift register and registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KERNEL; i++) begin
                for (int j = 0; j < KERNEL; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_capture) begin
                // Shift left; the fresh right column is rows r-2, r-1, r.
                for (int i = 0; i < KERNEL; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= w_lb0_rd;
                r_win[1][2] <= w_lb1_rd;
                r_win[2][2] <= w_pix;
                if (w_has_win) begin
                    r_win_row <= r_row - 5'd2;
                    r_win_col <= r_col - 5'd2;
                end
            end
            r_win_valid <= (w_next_state == EMIT);
            r_busy      <= (w_next_state == ADDR) || (w_next_state == DATA) ||
                           (w_next_state == EMIT);
            r_done      <= (w_next_state == DONE);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign win.win_pix[k*PIX_W +: PIX_W] = r_win[LANE_ROW[k]][LANE_COL[k]];
    end

    assign win.win_valid = r_win_valid;
    assign win.win_row   = r_win_row;
    assign win.win_col   = r_win_col;
    assign rom_row       = {1'b0, r_row};
    assign rom_col       = {4'b0, r_col};
    assign busy          = r_busy;
    assign done          = r_done;

endmodule
